// File: rtl/atm_txn_arbiter.sv
// Round-robin arbiter sharing one ATM transaction engine between N_REQ terminals.
// Each grant clears the engine, runs it for EXEC_CYCLES, then returns balance/success with a done pulse.
module atm_txn_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned EXEC_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_operation,
    input  logic [4*N_REQ-1:0]   req_acc_num,
    input  logic [16*N_REQ-1:0]  req_pin,
    input  logic [16*N_REQ-1:0]  req_new_pin,
    input  logic [32*N_REQ-1:0]  req_amount,
    input  logic [N_REQ-1:0]     req_language,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [31:0]          rsp_balance,
    output logic                 rsp_success,
    output logic                 rsp_reject,
    output logic                 busy,
    output logic                 eng_rst,
    output logic [2:0]           eng_operation,
    output logic [3:0]           eng_acc_num,
    output logic [15:0]          eng_pin,
    output logic [15:0]          eng_new_pin,
    output logic [31:0]          eng_amount,
    output logic                 eng_language,
    input  logic [31:0]          eng_balance,
    input  logic                 eng_success,
    output logic [15:0]          txn_count
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CLR, EXEC, RESP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_q;
    logic [PW-1:0] win_idx;
    logic          win_valid;
    logic [PW:0]   cand;
    logic [3:0]    cnt;
    logic          rej_q;
    logic [2:0]    win_op;
    logic          op_ok;
    logic          exec_last;

    assign win_op    = req_operation[3*win_idx +: 3];
    assign op_ok     = (win_op >= 3'd3) && (win_op <= 3'd6);
    assign exec_last = (cnt == 4'(EXEC_CYCLES - 1));
    assign busy      = (state != IDLE);

    // First asserted requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (!win_valid && req[cand[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Rejects also pass through CLR (engine reset left high) for a fixed two-cycle latency.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_valid) state_nxt = CLR;
            CLR:  state_nxt = rej_q ? RESP : EXEC;
            EXEC: if (exec_last) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt           <= '0;
            done          <= '0;
            rsp_balance   <= '0;
            rsp_success   <= 1'b0;
            rsp_reject    <= 1'b0;
            eng_rst       <= 1'b0;
            eng_operation <= '0;
            eng_acc_num   <= '0;
            eng_pin       <= '0;
            eng_new_pin   <= '0;
            eng_amount    <= '0;
            eng_language  <= 1'b0;
            txn_count     <= '0;
            ptr           <= '0;
            win_q         <= '0;
            cnt           <= '0;
            rej_q         <= 1'b0;
        end else begin
            done    <= '0;
            eng_rst <= 1'b1;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt           <= N_REQ'(1) << win_idx;
                        win_q         <= win_idx;
                        eng_operation <= win_op;
                        eng_acc_num   <= req_acc_num[4*win_idx +: 4];
                        eng_pin       <= req_pin[16*win_idx +: 16];
                        eng_new_pin   <= req_new_pin[16*win_idx +: 16];
                        eng_amount    <= req_amount[32*win_idx +: 32];
                        eng_language  <= req_language[win_idx];
                        rej_q         <= !op_ok;
                        if (op_ok) begin
                            eng_rst <= 1'b0;
                        end else begin
                            rsp_reject  <= 1'b1;
                            rsp_success <= 1'b0;
                            rsp_balance <= '0;
                        end
                    end
                end
                CLR: begin
                    cnt <= '0;
                    if (rej_q) done <= gnt;
                end
                EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (exec_last) begin
                        rsp_balance <= eng_balance;
                        rsp_success <= eng_success;
                        rsp_reject  <= 1'b0;
                        done        <= gnt;
                        if (txn_count != '1) txn_count <= txn_count + 1'b1;
                    end
                end
                RESP: begin
                    gnt <= '0;
                    ptr <= (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
